ccl_stream_labeler: RTL and testbench
=====================================

// Module: ccl_stream_labeler
// PURPOSE
//  Streaming first-pass connected-component labeler for the motion mask, one pixel per cycle, raster order.
//  Sits between the motion-mask stage and the equivalence/bounding-box stage.
//  Assigns each pixel a provisional label and reports new-label allocations and label merges.
//  Supports 4- or 8-connectivity and configurable label width and line length.
//  An internal previous-row label buffer replaces externally supplied left/top labels.
// PARAMETERS
//  LABEL_WIDTH   8    label bits; label 0 = background; max label = 2**LABEL_WIDTH-1
//  IMG_WIDTH     640  pixels per line (depth of row label buffer)
//  COL_WIDTH     10   column counter bits, >= $clog2(IMG_WIDTH)
//  CONNECTIVITY  4    4 = L,T neighbours; 8 = L,TL,T,TR neighbours
// PORTS
//  clk              in   1            clock
//  rst              in   1            asynchronous reset, active-low
//  enable           in   1            input pixel valid; low = stall, all state held
//  motion_pixel     in   1            1 = foreground pixel
//  last_in_line     in   1            qualifies final pixel of a line
//  last_in_frame    in   1            qualifies final pixel of a frame (implies last_in_line)
//  out_valid        out  1            current_label/flags valid this cycle
//  current_label    out  LABEL_WIDTH  provisional label of the pixel
//  new_label_valid  out  1            pulse: a fresh label was allocated
//  new_label_value  out  LABEL_WIDTH  the allocated label
//  merge_labels     out  1            pulse: two distinct labels are equivalent
//  merge_a          out  LABEL_WIDTH  smaller label of the pair
//  merge_b          out  LABEL_WIDTH  larger label of the pair
//  label_overflow   out  1            sticky within frame: label space exhausted
//  frame_done       out  1            pulse, coincident with out_valid of the last_in_frame pixel
//  num_labels       out  LABEL_WIDTH  labels allocated in the last completed frame
// BEHAVIOUR
//  - Reset: all outputs 0; next_label=1; col=0; first_row=1; row buffer contents don't-care.
//  - Latency: exactly 1 cycle. Each accepted pixel (enable=1) yields out_valid=1 on the next cycle.
//    Outputs are registered. Sustained throughput is 1 pixel/cycle.
//  - Neighbours: L = previous label in the line (0 at col 0).
//    T/TL/TR are read from the row buffer; all are 0 while first_row=1.
//    TL is 0 at col 0; TR is 0 on the last_in_line pixel. TL/TR are ignored when CONNECTIVITY=4.
//  - Label rules:
//    - motion_pixel=0: label 0; row buffer[col] <= 0.
//    - All neighbours 0: label=next_label; new_label_valid=1; next_label++.
//    - Otherwise: label = min of nonzero neighbours.
//      If min != max of nonzero neighbours: merge_labels=1, merge_a=min, merge_b=max.
//    - new_label_valid and merge_labels are never both set.
//  - Row buffer: buffer[col] is written with the output label. The read of T for col happens
//    before the write. Read-ahead is required so TR is available without a bubble.
//  - Column and row tracking: col increments per accepted pixel and resets to 0 after last_in_line.
//    first_row clears after the first last_in_line and sets again after last_in_frame.
//    IMG_WIDTH pixels without last_in_line: col wraps to 0 as if a line ended.
//  - Overflow: if allocation is needed while next_label = 2**LABEL_WIDTH, label = max label.
//    In that case no new_label_valid is issued and label_overflow=1 (sticky).
//  - Frame end: on the cycle after accepting last_in_frame:
//    - frame_done=1 and num_labels=next_label-1 (saturated at max label).
//    - next_label resets to 1, first_row=1, label_overflow clears on the next accepted pixel.
//  - Stall: enable=0 gives out_valid=0 and all pulses 0; no state changes.
//  - Async reset mid-frame: immediate return to reset state; the next pixel is treated as row 0, col 0.
// TESTING (IMG_WIDTH=4 unless noted)
//  1. Single fg pixel at row0 col1, rest 0, 2 rows, frame end
//     -> new_label_valid with value 1 at that pixel; frame_done with num_labels=1.
//  2. row0=1010, row1=1110
//     -> labels row0: 1,0,2,0; row1: 1,1,1,0; at row1 col2 merge_labels=1, merge_a=1, merge_b=2.
//  3. row0=1000, row1=0100
//     -> CONNECTIVITY=4: row1 col1 new label 2, num_labels=2;
//        CONNECTIVITY=8: label 1, no new label, num_labels=1.
//  4. LABEL_WIDTH=2, rows 1010/0000/1010
//     -> labels 1,2,3,3; label_overflow=1 at 4th fg pixel; num_labels=3; next frame first label=1, overflow=0.
//  5. Test 2 stimulus with enable toggled 1,0,1,0,...
//     -> identical out_valid-qualified label/merge sequence as the continuous run.
//  6. rst low after 3 pixels of row1, then a fresh frame of test 1
//     -> outputs 0 during reset; results identical to test 1.

Source files
------------

// File: rtl/ccl_stream_labeler.sv
// ccl_stream_labeler: streaming first-pass connected-component labeler, one pixel/cycle in raster order.
// Rev 1.0
`default_nettype none

module ccl_stream_labeler #(
   parameter int LABEL_WIDTH  = 8,
   parameter int IMG_WIDTH    = 640,
   parameter int COL_WIDTH    = 10,
   parameter int CONNECTIVITY = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   motion_pixel,
   input  logic                   last_in_line,
   input  logic                   last_in_frame,
   output logic                   out_valid,
   output logic [LABEL_WIDTH-1:0] current_label,
   output logic                   new_label_valid,
   output logic [LABEL_WIDTH-1:0] new_label_value,
   output logic                   merge_labels,
   output logic [LABEL_WIDTH-1:0] merge_a,
   output logic [LABEL_WIDTH-1:0] merge_b,
   output logic                   label_overflow,
   output logic                   frame_done,
   output logic [LABEL_WIDTH-1:0] num_labels
);

   localparam logic [LABEL_WIDTH-1:0] MAX_LABEL   = '1;
   localparam logic [LABEL_WIDTH:0]   FIRST_LABEL = (LABEL_WIDTH+1)'(1);
   localparam logic [COL_WIDTH-1:0]   LAST_COL    = COL_WIDTH'(IMG_WIDTH - 1);

   logic [LABEL_WIDTH-1:0] row_buf_q [IMG_WIDTH];

   logic [COL_WIDTH-1:0]   col_q, col_d;
   logic                   first_row_q, first_row_d;
   logic [LABEL_WIDTH:0]   next_label_q, next_label_d;
   logic [LABEL_WIDTH-1:0] left_q, left_d;
   logic [LABEL_WIDTH-1:0] tl_q, tl_d;

   logic                   out_valid_q, out_valid_d;
   logic [LABEL_WIDTH-1:0] current_label_q, current_label_d;
   logic                   new_label_valid_q, new_label_valid_d;
   logic [LABEL_WIDTH-1:0] new_label_value_q, new_label_value_d;
   logic                   merge_labels_q, merge_labels_d;
   logic [LABEL_WIDTH-1:0] merge_a_q, merge_a_d;
   logic [LABEL_WIDTH-1:0] merge_b_q, merge_b_d;
   logic                   label_overflow_q, label_overflow_d;
   logic                   frame_done_q, frame_done_d;
   logic [LABEL_WIDTH-1:0] num_labels_q, num_labels_d;

   logic                   at_last_col;
   logic                   line_end;
   logic [COL_WIDTH-1:0]   tr_idx;
   logic [LABEL_WIDTH-1:0] nb_l, nb_tl, nb_t, nb_tr;
   logic [LABEL_WIDTH-1:0] nb [4];
   logic [LABEL_WIDTH-1:0] nb_min, nb_max;
   logic                   nb_any;
   logic [LABEL_WIDTH-1:0] lbl;
   logic                   alloc, ovf, mrg;
   logic [LABEL_WIDTH:0]   next_label_inc;
   logic [LABEL_WIDTH:0]   alloc_count;

   assign at_last_col = (col_q == LAST_COL);
   assign line_end    = last_in_line | last_in_frame | at_last_col;
   assign tr_idx      = line_end ? col_q : col_q + 1'b1;

   // TL is the previous row's value at col-1, captured before this row overwrote it.
   always_comb begin
      nb_l  = (col_q == '0) ? '0 : left_q;
      nb_t  = first_row_q ? '0 : row_buf_q[col_q];
      nb_tl = '0;
      nb_tr = '0;
      if (CONNECTIVITY == 8) begin
         nb_tl = (col_q == '0) ? '0 : tl_q;
         nb_tr = (first_row_q || line_end) ? '0 : row_buf_q[tr_idx];
      end
      nb[0] = nb_l;
      nb[1] = nb_tl;
      nb[2] = nb_t;
      nb[3] = nb_tr;
   end

   always_comb begin
      nb_min = '1;
      nb_max = '0;
      nb_any = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (nb[i] != '0) begin
            nb_any = 1'b1;
            if (nb[i] < nb_min) nb_min = nb[i];
            if (nb[i] > nb_max) nb_max = nb[i];
         end
      end
   end

   always_comb begin
      lbl   = '0;
      alloc = 1'b0;
      ovf   = 1'b0;
      mrg   = 1'b0;
      if (motion_pixel) begin
         if (!nb_any) begin
            // next_label == 2**LABEL_WIDTH means the label space is used up.
            if (next_label_q[LABEL_WIDTH]) begin
               lbl = MAX_LABEL;
               ovf = 1'b1;
            end else begin
               lbl   = next_label_q[LABEL_WIDTH-1:0];
               alloc = 1'b1;
            end
         end else begin
            lbl = nb_min;
            mrg = (nb_min != nb_max);
         end
      end
   end

   assign next_label_inc = next_label_q + {{LABEL_WIDTH{1'b0}}, alloc};
   assign alloc_count    = next_label_inc - FIRST_LABEL;

   always_comb begin
      col_d             = col_q;
      first_row_d       = first_row_q;
      next_label_d      = next_label_q;
      left_d            = left_q;
      tl_d              = tl_q;
      out_valid_d       = 1'b0;
      current_label_d   = current_label_q;
      new_label_valid_d = 1'b0;
      new_label_value_d = new_label_value_q;
      merge_labels_d    = 1'b0;
      merge_a_d         = merge_a_q;
      merge_b_d         = merge_b_q;
      label_overflow_d  = label_overflow_q;
      frame_done_d      = 1'b0;
      num_labels_d      = num_labels_q;
      if (enable) begin
         out_valid_d       = 1'b1;
         current_label_d   = lbl;
         new_label_valid_d = alloc;
         new_label_value_d = alloc ? lbl : '0;
         merge_labels_d    = mrg;
         merge_a_d         = mrg ? nb_min : '0;
         merge_b_d         = mrg ? nb_max : '0;
         // Row 0, col 0 marks the first pixel of a frame: overflow restarts there.
         label_overflow_d  = ((first_row_q && col_q == '0) ? 1'b0 : label_overflow_q) | ovf;
         left_d            = lbl;
         tl_d              = nb_t;
         col_d             = line_end ? '0 : col_q + 1'b1;
         first_row_d       = line_end ? 1'b0 : first_row_q;
         next_label_d      = next_label_inc;
         if (last_in_frame) begin
            frame_done_d = 1'b1;
            num_labels_d = alloc_count[LABEL_WIDTH-1:0];
            first_row_d  = 1'b1;
            next_label_d = FIRST_LABEL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enable) row_buf_q[col_q] <= lbl;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q             <= '0;
         first_row_q       <= 1'b1;
         next_label_q      <= FIRST_LABEL;
         left_q            <= '0;
         tl_q              <= '0;
         out_valid_q       <= 1'b0;
         current_label_q   <= '0;
         new_label_valid_q <= 1'b0;
         new_label_value_q <= '0;
         merge_labels_q    <= 1'b0;
         merge_a_q         <= '0;
         merge_b_q         <= '0;
         label_overflow_q  <= 1'b0;
         frame_done_q      <= 1'b0;
         num_labels_q      <= '0;
      end else begin
         col_q             <= col_d;
         first_row_q       <= first_row_d;
         next_label_q      <= next_label_d;
         left_q            <= left_d;
         tl_q              <= tl_d;
         out_valid_q       <= out_valid_d;
         current_label_q   <= current_label_d;
         new_label_valid_q <= new_label_valid_d;
         new_label_value_q <= new_label_value_d;
         merge_labels_q    <= merge_labels_d;
         merge_a_q         <= merge_a_d;
         merge_b_q         <= merge_b_d;
         label_overflow_q  <= label_overflow_d;
         frame_done_q      <= frame_done_d;
         num_labels_q      <= num_labels_d;
      end
   end

   assign out_valid       = out_valid_q;
   assign current_label   = current_label_q;
   assign new_label_valid = new_label_valid_q;
   assign new_label_value = new_label_value_q;
   assign merge_labels    = merge_labels_q;
   assign merge_a         = merge_a_q;
   assign merge_b         = merge_b_q;
   assign label_overflow  = label_overflow_q;
   assign frame_done      = frame_done_q;
   assign num_labels      = num_labels_q;

endmodule

`default_nettype wire

// File: tb/tb_ccl_stream_labeler.sv
// tb_ccl_stream_labeler: directed bench, three labeler configurations driven by one shared stimulus stream.
// Rev 1.0
`default_nettype none

module tb_ccl_stream_labeler;

   logic clk = 1'b0;
   logic rst, enable, motion_pixel, last_in_line, last_in_frame;
   always #5 clk = ~clk;

   // a: 4-conn, 8-bit labels; b: 8-conn, 8-bit labels; c: 4-conn, 2-bit labels
   logic       a_ov, a_nv, a_mg, a_of, a_fd;
   logic [7:0] a_cl, a_nval, a_ma, a_mb, a_nl;
   logic       b_ov, b_nv, b_mg, b_of, b_fd;
   logic [7:0] b_cl, b_nval, b_ma, b_mb, b_nl;
   logic       c_ov, c_nv, c_mg, c_of, c_fd;
   logic [1:0] c_cl, c_nval, c_ma, c_mb, c_nl;

   ccl_stream_labeler #(.LABEL_WIDTH(8), .IMG_WIDTH(4), .COL_WIDTH(2), .CONNECTIVITY(4)) u_a (
      .clk(clk), .rst(rst), .enable(enable), .motion_pixel(motion_pixel),
      .last_in_line(last_in_line), .last_in_frame(last_in_frame),
      .out_valid(a_ov), .current_label(a_cl), .new_label_valid(a_nv), .new_label_value(a_nval),
      .merge_labels(a_mg), .merge_a(a_ma), .merge_b(a_mb), .label_overflow(a_of),
      .frame_done(a_fd), .num_labels(a_nl));

   ccl_stream_labeler #(.LABEL_WIDTH(8), .IMG_WIDTH(4), .COL_WIDTH(2), .CONNECTIVITY(8)) u_b (
      .clk(clk), .rst(rst), .enable(enable), .motion_pixel(motion_pixel),
      .last_in_line(last_in_line), .last_in_frame(last_in_frame),
      .out_valid(b_ov), .current_label(b_cl), .new_label_valid(b_nv), .new_label_value(b_nval),
      .merge_labels(b_mg), .merge_a(b_ma), .merge_b(b_mb), .label_overflow(b_of),
      .frame_done(b_fd), .num_labels(b_nl));

   ccl_stream_labeler #(.LABEL_WIDTH(2), .IMG_WIDTH(4), .COL_WIDTH(2), .CONNECTIVITY(4)) u_c (
      .clk(clk), .rst(rst), .enable(enable), .motion_pixel(motion_pixel),
      .last_in_line(last_in_line), .last_in_frame(last_in_frame),
      .out_valid(c_ov), .current_label(c_cl), .new_label_valid(c_nv), .new_label_value(c_nval),
      .merge_labels(c_mg), .merge_a(c_ma), .merge_b(c_mb), .label_overflow(c_of),
      .frame_done(c_fd), .num_labels(c_nl));

   int vectors = 0;
   int miscompares = 0;
   int px;

   // Per-pixel captures of the current frame, indexed by raster position.
   logic       ca_ov [16];
   logic [7:0] ca_lab [16];
   logic       ca_nv [16];
   logic [7:0] ca_nval [16];
   logic       ca_mg [16];
   logic [7:0] ca_ma [16];
   logic [7:0] ca_mb [16];
   logic [7:0] cb_lab [16];
   logic       cb_nv [16];
   logic [1:0] cc_lab [16];
   logic       cc_of [16];

   logic [7:0] exp2 [8] = '{8'd1, 8'd0, 8'd2, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic idle();
      enable = 1'b0; motion_pixel = 1'b0; last_in_line = 1'b0; last_in_frame = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic send(input logic m, input logic lil, input logic lif, input bit gap);
      enable = 1'b1; motion_pixel = m; last_in_line = lil; last_in_frame = lif;
      @(posedge clk); #1;
      ca_ov[px] = a_ov;  ca_lab[px] = a_cl; ca_nv[px] = a_nv; ca_nval[px] = a_nval;
      ca_mg[px] = a_mg;  ca_ma[px] = a_ma;  ca_mb[px] = a_mb;
      cb_lab[px] = b_cl; cb_nv[px] = b_nv;
      cc_lab[px] = c_cl; cc_of[px] = c_of;
      px++;
      if (gap) begin
         idle();
         chk("stall_out_valid", a_ov, 0);
         chk("stall_pulses", {a_nv, a_mg, a_fd}, 0);
      end
   endtask

   task automatic row(input logic [3:0] r, input bit lastf, input bit gap);
      for (int i = 0; i < 4; i++) send(r[3-i], i == 3, lastf && i == 3, gap);
   endtask

   initial begin
      rst = 1'b0; enable = 1'b0; motion_pixel = 1'b0; last_in_line = 1'b0; last_in_frame = 1'b0;
      #12;
      chk("reset_outputs_a", {a_ov, a_cl, a_nv, a_nval, a_mg, a_ma, a_mb, a_of, a_fd, a_nl}, 0);
      chk("reset_outputs_c", {c_ov, c_cl, c_nv, c_of, c_fd, c_nl}, 0);
      #5 rst = 1'b1;
      idle();

      // Test 1: single foreground pixel
      px = 0; row(4'b0100, 0, 0); row(4'b0000, 1, 0);
      chk("t1_frame_done", a_fd, 1);
      chk("t1_num_labels", a_nl, 1);
      chk("t1_label", ca_lab[1], 1);
      chk("t1_new_valid", ca_nv[1], 1);
      chk("t1_new_value", ca_nval[1], 1);
      idle();
      chk("t1_frame_done_pulse", a_fd, 0);

      // Test 2: merge of labels 1 and 2
      px = 0; row(4'b1010, 0, 0); row(4'b1110, 1, 0);
      chk("t2_num_labels", a_nl, 2);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t2_label_%0d", i), ca_lab[i], exp2[i]);
         chk($sformatf("t2_merge_%0d", i), ca_mg[i], (i == 6) ? 1 : 0);
      end
      chk("t2_merge_a", ca_ma[6], 1);
      chk("t2_merge_b", ca_mb[6], 2);
      chk("t2_new_valid_col2", ca_nv[2], 1);
      chk("t2_new_value_col2", ca_nval[2], 2);
      idle();

      // Test 3: diagonal neighbour, 4- vs 8-connectivity
      px = 0; row(4'b1000, 0, 0); row(4'b0100, 1, 0);
      chk("t3_c4_label", ca_lab[5], 2);
      chk("t3_c4_new", ca_nv[5], 1);
      chk("t3_c4_num", a_nl, 2);
      chk("t3_c8_label", cb_lab[5], 1);
      chk("t3_c8_new", cb_nv[5], 0);
      chk("t3_c8_num", b_nl, 1);
      idle();

      // Test 4: label space exhaustion with 2-bit labels
      px = 0; row(4'b1010, 0, 0); row(4'b0000, 0, 0); row(4'b1010, 1, 0);
      chk("t4_label_0", cc_lab[0], 1);
      chk("t4_label_2", cc_lab[2], 2);
      chk("t4_label_8", cc_lab[8], 3);
      chk("t4_label_10", cc_lab[10], 3);
      chk("t4_ovf_before", cc_of[8], 0);
      chk("t4_ovf_at_4th", cc_of[10], 1);
      chk("t4_ovf_sticky", cc_of[11], 1);
      chk("t4_num_labels", c_nl, 3);
      chk("t4_a_num_labels", a_nl, 4);
      idle();

      // Test 5: test 2 with enable toggled; also next frame after overflow on c
      px = 0; row(4'b1010, 0, 1); row(4'b1110, 1, 1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("t5_valid_%0d", i), ca_ov[i], 1);
         chk($sformatf("t5_label_%0d", i), ca_lab[i], exp2[i]);
         chk($sformatf("t5_merge_%0d", i), ca_mg[i], (i == 6) ? 1 : 0);
      end
      chk("t5_merge_a", ca_ma[6], 1);
      chk("t5_merge_b", ca_mb[6], 2);
      chk("t5_num_labels", a_nl, 2);
      chk("t5_c_first_label", cc_lab[0], 1);
      chk("t5_c_ovf_cleared", cc_of[0], 0);

      // Test 6: asynchronous reset part way through row 1
      px = 0; row(4'b1010, 0, 0);
      send(1, 0, 0, 0); send(1, 0, 0, 0); send(1, 0, 0, 0);
      enable = 1'b0; motion_pixel = 1'b0;
      rst = 1'b0;
      #1;
      chk("t6_reset_outputs", {a_ov, a_cl, a_nv, a_nval, a_mg, a_ma, a_mb, a_of, a_fd, a_nl}, 0);
      @(posedge clk); #1;
      chk("t6_reset_held", {a_ov, a_cl, a_nv, a_fd, a_nl}, 0);
      #2 rst = 1'b1;
      idle();
      px = 0; row(4'b0100, 0, 0); row(4'b0000, 1, 0);
      chk("t6_label", ca_lab[1], 1);
      chk("t6_new_valid", ca_nv[1], 1);
      chk("t6_new_value", ca_nval[1], 1);
      chk("t6_col0_label", ca_lab[0], 0);
      chk("t6_frame_done", a_fd, 1);
      chk("t6_num_labels", a_nl, 1);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
